writeback_buffer: RTL
=====================

Name: writeback_buffer

Overview:
- Dual-lane writeback stage between the execute/memory pipes and the two-port register file write side.
- Accepts an in-order pair of results per handshake: lane 1 is older, lane 2 is younger.
- Buffers pairs in a FIFO so writeback can be held, then drains one pair per cycle onto registered write ports.
- Provides a youngest-first bypass lookup over every result not yet committed to the register file.

Parameters:
DEPTH, 4, FIFO depth in pairs; power of two, >= 2
DW, 32, data width
AW, 5, register address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset; 0 = reset asserted
in_valid  in  1  upstream pair valid
in_ready  out  1  buffer can accept a pair
in_we_1  in  1  lane 1 writes a register
in_rd_1  in  AW  lane 1 destination
in_data_1  in  DW  lane 1 result
in_we_2  in  1  lane 2 writes a register
in_rd_2  in  AW  lane 2 destination
in_data_2  in  DW  lane 2 result
wb_hold  in  1  suppress drain this cycle
rd_1  out  AW  write port 1 address (older lane)
writedata_1  out  DW  write port 1 data
reg_write_1  out  1  write port 1 enable
rd_2  out  AW  write port 2 address (younger lane)
writedata_2  out  DW  write port 2 data
reg_write_2  out  1  write port 2 enable
byp_rs_a  in  AW  bypass query A
byp_hit_a  out  1  query A matches a pending write
byp_data_a  out  DW  newest pending value for query A
byp_rs_b  in  AW  bypass query B
byp_hit_b  out  1  query B matches a pending write
byp_data_b  out  DW  newest pending value for query B
count  out  $clog2(DEPTH)+1  occupied FIFO entries
empty  out  1  count == 0

Behaviour:
- Reset (reset == 0, asynchronous): read/write pointers and count = 0; empty = 1; all rd_*, writedata_*, reg_write_* = 0; all FIFO entry enables = 0. Any pending results are discarded.
- in_ready = (count != DEPTH). It is combinational from count only and does not look ahead to a same-cycle pop.
- Enqueue on a rising edge when in_valid && in_ready. The stored enable for each lane is forced to 0 when its rd == 0.
- If both lanes are enabled with rd_1 == rd_2, the stored lane 1 enable is cleared, because the younger value wins.
- A pair with both enables 0 is still enqueued and occupies a slot.
- Pop on a rising edge when !wb_hold && !empty. The output registers load the head entry.
- When no pop occurs, reg_write_1 and reg_write_2 are 0 on the next cycle; rd_* and writedata_* hold their last values.
- Latency: a pair accepted at edge N into an empty buffer with wb_hold = 0 is presented on the write ports after edge N+1, and is committed to the register file at edge N+2.
- Simultaneous enqueue and pop: count is unchanged and both pointers advance.
- When full, an enqueue is refused even if a pop occurs in the same cycle.
- Pointers wrap modulo DEPTH.
- Bypass lookup is combinational. Sources, newest first:
  - FIFO entries, tail-1 back to head; within an entry, lane 2 before lane 1.
  - Then the output register: lane 2 before lane 1, only while its reg_write is 1.
- The first enabled source whose rd equals the query gives hit = 1 and its data.
- No match, or query == 0: hit = 0, data = 0.
- The bypass does not include the same-cycle in_* pair.
- wb_hold has no effect on enqueue or bypass.

Test Plan:
- Reset: assert reset low mid-traffic with count = 3 -> immediately count = 0, empty = 1, reg_write_1/2 = 0, in_ready = 1; after release, old data never appears on the write ports.
- Latency and ordering: enqueue (we1, rd 5, 0x11; we2, rd 6, 0x22) into an empty buffer, wb_hold = 0 -> the next cycle shows rd_1 = 5, writedata_1 = 0x11, rd_2 = 6, writedata_2 = 0x22, reg_write_1 = reg_write_2 = 1; the cycle after, both enables are 0.
- Same-rd pair: enqueue (we1, rd 7, 0xA; we2, rd 7, 0xB) -> output reg_write_1 = 0, reg_write_2 = 1, writedata_2 = 0xB. Pair with rd_1 = 0 and we1 = 1 -> reg_write_1 = 0.
- Full/backpressure: hold wb_hold = 1 and offer 5 pairs -> 4 accepted, in_ready = 0 with count = 4. Release hold with in_valid = 1 -> one pop per cycle, and in_ready rises one cycle after the first pop. Pairs drain in order, and wrap-around over 2*DEPTH pairs shows no corruption.
- Bypass priority: with wb_hold = 1, enqueue (rd 3 = 0x1) then (rd 3 = 0x2, lane 1) and (rd 9 = 0x3, lane 2) -> query 3 hits 0x2. Pop twice -> query 3 hits from the output register, then misses (hit = 0, data = 0). Query 0 -> always hit = 0.
- Simultaneous push and pop at count = 2 with wb_hold = 0 -> count stays 2 and head data appears on the ports the next cycle.

Source files
------------

// File: rtl/writeback_buffer.sv
// writeback_buffer
//   Dual-lane writeback stage sitting between the execute/memory pipes and the
//   two write ports of the register file. Each handshake accepts an in-order
//   pair of results: lane 1 is older and lane 2 is younger. Pairs are queued
//   in a FIFO so that writeback can be held. The FIFO drains one pair per cycle
//   into registered write ports. A combinational bypass returns the newest
//   value that has not yet been committed to the register file.
//
// Ports
//   clk, reset                  rising-edge clock, async active-low reset
//   in_valid / in_ready         upstream pair handshake
//   in_we_N, in_rd_N, in_data_N lane N (1 = older, 2 = younger) result
//   wb_hold                     suppresses the drain for this cycle
//   rd_N, writedata_N,
//   reg_write_N                 registered register-file write port N
//   byp_rs_X / byp_hit_X /
//   byp_data_X                  bypass queries A and B
//   count, empty                FIFO occupancy in pairs
module writeback_buffer #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_we_1,
  input  logic [AW-1:0]          in_rd_1,
  input  logic [DW-1:0]          in_data_1,
  input  logic                   in_we_2,
  input  logic [AW-1:0]          in_rd_2,
  input  logic [DW-1:0]          in_data_2,
  input  logic                   wb_hold,
  output logic [AW-1:0]          rd_1,
  output logic [DW-1:0]          writedata_1,
  output logic                   reg_write_1,
  output logic [AW-1:0]          rd_2,
  output logic [DW-1:0]          writedata_2,
  output logic                   reg_write_2,
  input  logic [AW-1:0]          byp_rs_a,
  output logic                   byp_hit_a,
  output logic [DW-1:0]          byp_data_a,
  input  logic [AW-1:0]          byp_rs_b,
  output logic                   byp_hit_b,
  output logic [DW-1:0]          byp_data_b,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int              PW   = $clog2(DEPTH);
  localparam int              CW   = PW + 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  logic [DEPTH-1:0] r_we_1;
  logic [DEPTH-1:0] r_we_2;
  logic [AW-1:0]    r_rd_1   [DEPTH];
  logic [AW-1:0]    r_rd_2   [DEPTH];
  logic [DW-1:0]    r_data_1 [DEPTH];
  logic [DW-1:0]    r_data_2 [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic             w_push;
  logic             w_pop;
  logic             w_we_1;
  logic             w_we_2;
  logic [PW-1:0]    w_idx;

  assign count    = r_count;
  assign empty    = (r_count == '0);
  // Full is judged from the occupancy alone. A pop in the same cycle does not
  // free a slot for an incoming pair.
  assign in_ready = (r_count != FULL);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = !wb_hold && !empty;

  // x0 is never written. When both lanes target the same register, the older
  // lane is dropped because the younger value would overwrite it anyway.
  assign w_we_2 = in_we_2 && (in_rd_2 != '0);
  assign w_we_1 = in_we_1 && (in_rd_1 != '0) && !(w_we_2 && (in_rd_1 == in_rd_2));

  // Control state: the pointers, the occupancy and the per-entry enables.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_we_1  <= '0;
      r_we_2  <= '0;
    end else begin
      if (w_push) begin
        r_we_1[r_wptr] <= w_we_1;
        r_we_2[r_wptr] <= w_we_2;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO payload. It is only meaningful while the matching enable is set.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd_1[r_wptr]   <= in_rd_1;
      r_rd_2[r_wptr]   <= in_rd_2;
      r_data_1[r_wptr] <= in_data_1;
      r_data_2[r_wptr] <= in_data_2;
    end
  end

  // Register-file write ports. The enables are asserted for exactly one cycle
  // per pop. The address and data hold their last values otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_1        <= '0;
      writedata_1 <= '0;
      reg_write_1 <= 1'b0;
      rd_2        <= '0;
      writedata_2 <= '0;
      reg_write_2 <= 1'b0;
    end else if (w_pop) begin
      rd_1        <= r_rd_1[r_rptr];
      writedata_1 <= r_data_1[r_rptr];
      reg_write_1 <= r_we_1[r_rptr];
      rd_2        <= r_rd_2[r_rptr];
      writedata_2 <= r_data_2[r_rptr];
      reg_write_2 <= r_we_2[r_rptr];
    end else begin
      reg_write_1 <= 1'b0;
      reg_write_2 <= 1'b0;
    end
  end

  // Bypass: sources are scanned oldest to newest and every later match
  // overwrites an earlier one, so the youngest pending write wins. The order
  // is: output register lane 1, then lane 2, then the FIFO from head to tail
  // with lane 1 before lane 2 inside each entry.
  always_comb begin
    byp_hit_a  = 1'b0;
    byp_data_a = '0;
    byp_hit_b  = 1'b0;
    byp_data_b = '0;
    w_idx      = r_rptr;
    if (reg_write_1 && (rd_1 == byp_rs_a)) begin
      byp_hit_a  = 1'b1;
      byp_data_a = writedata_1;
    end
    if (reg_write_2 && (rd_2 == byp_rs_a)) begin
      byp_hit_a  = 1'b1;
      byp_data_a = writedata_2;
    end
    if (reg_write_1 && (rd_1 == byp_rs_b)) begin
      byp_hit_b  = 1'b1;
      byp_data_b = writedata_1;
    end
    if (reg_write_2 && (rd_2 == byp_rs_b)) begin
      byp_hit_b  = 1'b1;
      byp_data_b = writedata_2;
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rptr + PW'(i);
      if (i < int'(r_count)) begin
        if (r_we_1[w_idx] && (r_rd_1[w_idx] == byp_rs_a)) begin
          byp_hit_a  = 1'b1;
          byp_data_a = r_data_1[w_idx];
        end
        if (r_we_2[w_idx] && (r_rd_2[w_idx] == byp_rs_a)) begin
          byp_hit_a  = 1'b1;
          byp_data_a = r_data_2[w_idx];
        end
        if (r_we_1[w_idx] && (r_rd_1[w_idx] == byp_rs_b)) begin
          byp_hit_b  = 1'b1;
          byp_data_b = r_data_1[w_idx];
        end
        if (r_we_2[w_idx] && (r_rd_2[w_idx] == byp_rs_b)) begin
          byp_hit_b  = 1'b1;
          byp_data_b = r_data_2[w_idx];
        end
      end
    end
    // Register 0 is hardwired, so it never reports a pending value.
    if (byp_rs_a == '0) begin
      byp_hit_a  = 1'b0;
      byp_data_a = '0;
    end
    if (byp_rs_b == '0) begin
      byp_hit_b  = 1'b0;
      byp_data_b = '0;
    end
  end

endmodule
